// File: rtl/sie_pkg.sv
// -----------------------------------------------------------------------------
// sie_pkg
// Shared definitions for the Schumann Ignition Event (SIE) sequencing path.
// The configuration controller, the phase sequencer and the downstream
// oscillator/coupling blocks all import the same phase codes from here.
//   DUR_W        : default width of duration words and countdowns
//   sie_phase_e  : 3-bit phase code; code 0 is never driven by the sequencer
// -----------------------------------------------------------------------------
package sie_pkg;

   localparam int DUR_W = 16;

   typedef enum logic [2:0] {
      SIE_ILLEGAL     = 3'd0,
      SIE_IDLE        = 3'd1,
      SIE_COHERENCE   = 3'd2,
      SIE_IGNITION    = 3'd3,
      SIE_PLATEAU     = 3'd4,
      SIE_PROPAGATION = 3'd5,
      SIE_DECAY       = 3'd6,
      SIE_REFRACTORY  = 3'd7
   } sie_phase_e;

endpackage

// File: rtl/sie_countdown.sv
// -----------------------------------------------------------------------------
// sie_countdown
// Load / decrement / zero-flag counter used as the per-phase countdown.
//   clk, rst   : system clock, synchronous active-high reset
//   clk_en     : 4 kHz update strobe; load and decrement only act when high
//   clr        : immediate clear, independent of clk_en
//   load       : load load_val (priority over decrement)
//   load_val   : value to load
//   count      : current count
//   zero       : count == 0
// The count never wraps: it only decrements while non-zero.
// -----------------------------------------------------------------------------
module sie_countdown #(
   parameter int DUR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             clr,
   input  logic             load,
   input  logic [DUR_W-1:0] load_val,
   output logic [DUR_W-1:0] count,
   output logic             zero
);

   logic [DUR_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (clk_en) begin
         if (load) begin
            r_count <= load_val;
         end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign count = r_count;
   assign zero  = (r_count == '0);

endmodule

// File: rtl/sie_phase_sequencer.sv
// -----------------------------------------------------------------------------
// sie_phase_sequencer
// Walks one Schumann Ignition Event through COHERENCE, IGNITION, PLATEAU,
// PROPAGATION and DECAY on a trigger, then holds REFRACTORY before IDLE.
// Durations are latched at acceptance; each phase lasts max(dur,1) clk_en
// cycles.
//   clk, rst            : system clock, synchronous active-high reset
//   clk_en              : 4 kHz update strobe (1 count = 250 us)
//   trigger, abort      : event request / early termination (clk_en cycles)
//   sie_phaseN_dur      : phase 2..6 durations in clk_en counts
//   sie_refractory      : refractory duration in clk_en counts
//   sie_phase           : current phase code
//   sie_active          : high in phases 2..6
//   phase_remaining     : clk_en counts left in the current phase, minus 1
//   sie_start/sie_done  : one-clk pulses at acceptance / decay end or abort
//   trig_rejected       : one-clk pulse for a trigger outside IDLE
//   event_count         : accepted events, saturating at all-ones
// -----------------------------------------------------------------------------
module sie_phase_sequencer #(
   parameter int DUR_W = sie_pkg::DUR_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             trigger,
   input  logic             abort,
   input  logic [DUR_W-1:0] sie_phase2_dur,
   input  logic [DUR_W-1:0] sie_phase3_dur,
   input  logic [DUR_W-1:0] sie_phase4_dur,
   input  logic [DUR_W-1:0] sie_phase5_dur,
   input  logic [DUR_W-1:0] sie_phase6_dur,
   input  logic [DUR_W-1:0] sie_refractory,
   output logic [2:0]       sie_phase,
   output logic             sie_active,
   output logic [DUR_W-1:0] phase_remaining,
   output logic             sie_start,
   output logic             sie_done,
   output logic             trig_rejected,
   output logic [CNT_W-1:0] event_count
);

   import sie_pkg::*;

   // Countdown load value for a duration: max(d,1) - 1
   function automatic logic [DUR_W-1:0] eff_m1(input logic [DUR_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   sie_phase_e       r_phase;
   logic             r_active, r_start, r_done, r_rej;
   logic [CNT_W-1:0] r_count;
   logic [DUR_W-1:0] r_p2, r_p3, r_p4, r_p5, r_p6, r_refr;

   logic             w_mid, w_zero, w_load, w_clr;
   logic [DUR_W-1:0] w_load_val, w_rem;

   assign w_mid = (r_phase inside {SIE_COHERENCE, SIE_IGNITION, SIE_PLATEAU,
                                   SIE_PROPAGATION, SIE_DECAY});
   assign w_clr = (r_phase == SIE_ILLEGAL);

   // Countdown reload decision; the FSM below makes the matching phase move.
   // Phase 2 loads from the live input since the snapshot is taken on the
   // same edge.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      if (r_phase == SIE_IDLE) begin
         w_load     = trigger;
         w_load_val = eff_m1(sie_phase2_dur);
      end else if (w_mid && abort) begin
         w_load     = 1'b1;
         w_load_val = eff_m1(r_refr);
      end else if (w_mid && w_zero) begin
         w_load = 1'b1;
         case (r_phase)
            SIE_COHERENCE:   w_load_val = eff_m1(r_p3);
            SIE_IGNITION:    w_load_val = eff_m1(r_p4);
            SIE_PLATEAU:     w_load_val = eff_m1(r_p5);
            SIE_PROPAGATION: w_load_val = eff_m1(r_p6);
            default:         w_load_val = eff_m1(r_refr);
         endcase
      end
   end

   sie_countdown #(.DUR_W(DUR_W)) u_countdown (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .clr      (w_clr),
      .load     (w_load),
      .load_val (w_load_val),
      .count    (w_rem),
      .zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase  <= SIE_IDLE;
         r_active <= 1'b0;
         r_start  <= 1'b0;
         r_done   <= 1'b0;
         r_rej    <= 1'b0;
         r_count  <= '0;
         r_p2     <= '0;
         r_p3     <= '0;
         r_p4     <= '0;
         r_p5     <= '0;
         r_p6     <= '0;
         r_refr   <= '0;
      end else begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         r_rej   <= 1'b0;
         if (r_phase == SIE_ILLEGAL) begin
            // Corrupted state code: recover without waiting for clk_en
            r_phase  <= SIE_IDLE;
            r_active <= 1'b0;
         end else if (clk_en) begin
            if (r_phase == SIE_IDLE) begin
               if (trigger) begin
                  r_phase  <= SIE_COHERENCE;
                  r_active <= 1'b1;
                  r_start  <= 1'b1;
                  r_p2     <= sie_phase2_dur;
                  r_p3     <= sie_phase3_dur;
                  r_p4     <= sie_phase4_dur;
                  r_p5     <= sie_phase5_dur;
                  r_p6     <= sie_phase6_dur;
                  r_refr   <= sie_refractory;
                  if (r_count != '1) r_count <= r_count + 1'b1;
               end
            end else begin
               // Triggers are never queued outside IDLE
               r_rej <= trigger;
               if (w_mid && abort) begin
                  r_phase  <= SIE_REFRACTORY;
                  r_active <= 1'b0;
                  r_done   <= 1'b1;
               end else if (w_zero) begin
                  case (r_phase)
                     SIE_COHERENCE:   r_phase <= SIE_IGNITION;
                     SIE_IGNITION:    r_phase <= SIE_PLATEAU;
                     SIE_PLATEAU:     r_phase <= SIE_PROPAGATION;
                     SIE_PROPAGATION: r_phase <= SIE_DECAY;
                     SIE_DECAY: begin
                        r_phase  <= SIE_REFRACTORY;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                     end
                     default: begin
                        r_phase  <= SIE_IDLE;
                        r_active <= 1'b0;
                     end
                  endcase
               end
            end
         end
      end
   end

   assign sie_phase       = r_phase;
   assign sie_active      = r_active;
   assign phase_remaining = w_rem;
   assign sie_start       = r_start;
   assign sie_done        = r_done;
   assign trig_rejected   = r_rej;
   assign event_count     = r_count;

endmodule
